// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bundle between the MEM stage and the data-memory
// responder.
//   req_valid/req_ready : request handshake (accept when both high at clk edge)
//   req_we, req_be      : store flag and byte enables (enables ignored on loads)
//   req_addr, req_wdata : byte address and store data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata, rsp_err  : load data and error flag, zero unless rsp_valid
//   busy                : transaction outstanding, feeds pipeline stall logic
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the MEM stage. Accepts one load/store at a time,
// waits LATENCY cycles, performs the access on an internal word array and
// returns a single-cycle response.
// Parameters:
//   DEPTH_LOG2 : log2 of the array depth in 32-bit words
//   LATENCY    : wait states inserted before the access (0..15)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_responder_if slave modport (request/response/busy)
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           mem [WORDS];

    logic                  accept;
    logic                  addr_err;
    logic                  do_access;
    logic [DEPTH_LOG2-1:0] idx;

    // Ready is a pure state decode; it is also held low while reset is
    // asserted so nothing can be accepted during reset.
    assign bus.req_ready = !reset && (state != WAIT);
    assign accept        = bus.req_valid && bus.req_ready;

    // A shift keeps the out-of-range test valid for any DEPTH_LOG2.
    assign addr_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign idx       = addr_q[DEPTH_LOG2+1:2];
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    assign bus.busy      = (state == WAIT);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Control FSM. The request is captured on accept; in WAIT the counter runs
    // down and the access happens on the edge where it is already zero. The
    // response registers are cleared when leaving RESP so they read zero
    // whenever rsp_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= WAIT;
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= RESP;
                        err_q   <= addr_err;
                        rdata_q <= (!we_q && !addr_err) ? mem[idx] : 32'd0;
                    end
                end
                RESP: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    state   <= accept ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase

            // accept is only possible in IDLE/RESP, so this never collides
            // with the WAIT countdown.
            if (accept) begin
                we_q    <= bus.req_we;
                be_q    <= bus.req_be;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                cnt     <= LAT;
            end
        end
    end

    // Byte-masked array write. No reset here so the array keeps its contents;
    // a reset mid-transaction forces state to IDLE, which suppresses the write.
    always_ff @(posedge clk) begin
        if (do_access && we_q && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the MIPS pipeline's MEM-stage load/store requests. Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, then performs the read or byte-masked write on an internal word array and returns a single-cycle response. `busy` feeds the pipeline stall logic so the CPU holds its MEM stage while a transaction is outstanding.

## Interface
- `DEPTH_LOG2`, default 10: log2 of array depth in 32-bit words (4 KB default).
- `LATENCY`, default 2: wait states, legal range 0..15.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_be`  in  4  byte enables for stores; bit i selects bits [8i+7:8i]. Ignored on loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept this cycle.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or out of range; valid with `rsp_valid`.
- `busy`  out  1  transaction outstanding (state WAIT).

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` tracks wait states.
- Accept = `req_valid & req_ready` at a rising edge. Accept captures `we`, `be`, `addr`, `wdata`, loads `cnt <= LATENCY`, and moves to WAIT.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT.
- IDLE: on accept go to WAIT, otherwise stay.
- WAIT: if `cnt != 0`, decrement and stay. If `cnt == 0`, perform the access at this edge and go to RESP.
- RESP: `rsp_valid` = 1. On accept go to WAIT (back-to-back), otherwise go to IDLE.
- Error check on the captured request:
  - `addr[1:0] != 0`, or
  - `addr[31:DEPTH_LOG2+2] != 0`.
- On error: no array write, `rsp_rdata` = 0, `rsp_err` = 1.
- Load: `rsp_rdata` = `mem[addr[DEPTH_LOG2+1:2]]`, sampled at the access edge.
- Store: only bytes with `be` = 1 are written, at the access edge; `rsp_rdata` = 0. A store with `be` = 0000 completes normally with no change to the array.
- `rsp_rdata` and `rsp_err` are registered and are 0 whenever `rsp_valid` = 0.
- Reset, at any time including mid-transaction:
  - state IDLE, `cnt` = 0.
  - All outputs 0, except `req_ready` = 1 once reset is deasserted (0 while reset is asserted).
  - A pending transaction is dropped: no write, no response.
  - Array contents are not cleared by reset.

## Timing
- Accept at edge T. Access at edge T+1+LATENCY. `rsp_valid` high for exactly the cycle following that edge.
- Minimum request-to-response: 2 cycles (LATENCY = 0).
- `busy` is high for LATENCY+1 cycles per transaction.
- Sustained back-to-back throughput: one transaction per LATENCY+2 cycles, because accept in RESP overlaps the response cycle.
- A load issued in RESP, to the address just stored, returns the new data; the write completes at edge T+1+LATENCY of the previous transaction, before the next access edge.
- `req_*` inputs are sampled only at the accept edge and may change afterwards.
- No combinational path from `req_*` to any output. `req_ready` and `busy` decode state only.

## Test plan
- Reset then idle, LATENCY = 2: `req_ready` = 1, `busy` = 0, `rsp_valid` = 0 throughout.
- Store then load, LATENCY = 2:
  - Store `wdata` = 0xDEADBEEF, `be` = 1111, `addr` = 0x10, accepted at T: `busy` high T+1..T+3, `rsp_valid` at T+4 with `rsp_err` = 0.
  - Load of 0x10: returns 0xDEADBEEF.
- Byte-masked store, LATENCY = 2: after the above, store 0x000000AA with `be` = 0001, `addr` = 0x10; then load 0x10 returns 0xDEADBEAA.
- Errors:
  - `addr` = 0x12 (misaligned) → `rsp_err` = 1, `rsp_rdata` = 0, array unchanged.
  - `addr` = 0x1000 (out of range, DEPTH_LOG2 = 10) → `rsp_err` = 1.
- LATENCY = 0, back-to-back: three loads with `req_valid` held high → responses every 2 cycles, first at T+2.
- Reset mid-transaction: assert reset during WAIT of a store to 0x20 → no `rsp_valid`. A later load of 0x20 returns the pre-store value.
